// File: rtl/rv32i_instr_encoder.sv
// RV32I instruction encoder: field-level requests in, packed 32-bit words out.
// An li request may expand into LUI + ADDI; illegal requests yield NOP_WORD with err set.
module rv32i_instr_encoder #(
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_kind,
  input  logic [2:0]  req_funct3,
  input  logic        req_variant,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  input  logic [31:0] req_imm,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_word,
  output logic        instr_err,
  output logic        instr_last
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [3:0] K_LUI   = 4'd0;
  localparam logic [3:0] K_AUIPC = 4'd1;
  localparam logic [3:0] K_JAL   = 4'd2;
  localparam logic [3:0] K_JALR  = 4'd3;
  localparam logic [3:0] K_BR    = 4'd4;
  localparam logic [3:0] K_LOAD  = 4'd5;
  localparam logic [3:0] K_STORE = 4'd6;
  localparam logic [3:0] K_IMM   = 4'd7;
  localparam logic [3:0] K_REG   = 4'd8;
  localparam logic [3:0] K_LI    = 4'd9;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_LI_LO = 1'b1} state_t;

  state_t      state_q, state_d;
  logic        valid_q, valid_d;
  logic [31:0] word_q, word_d;
  logic        err_q, err_d;
  logic        last_q, last_d;
  logic [31:0] tail_q, tail_d;

  logic [31:0] enc_word;
  logic        enc_err;
  logic        enc_two;
  logic [31:0] enc_tail;
  logic [31:0] raw_word;
  logic        legal;
  logic [31:0] li_hi;
  logic [6:0]  funct7;
  logic        imm_i_ok;
  logic        imm_b_ok;
  logic        imm_j_ok;
  logic        imm_sh_ok;
  logic        fire_out;

  // Range checks: the value must sign-extend from the field width.
  assign imm_i_ok  = (&req_imm[31:11]) | ~(|req_imm[31:11]);
  assign imm_b_ok  = ((&req_imm[31:12]) | ~(|req_imm[31:12])) & ~req_imm[0];
  assign imm_j_ok  = ((&req_imm[31:20]) | ~(|req_imm[31:20])) & ~req_imm[0];
  assign imm_sh_ok = ~(|req_imm[31:5]);
  assign funct7    = req_variant ? 7'b0100000 : 7'b0000000;

  // Combinational encode of the request into its first word (and li tail word).
  always_comb begin
    raw_word = '0;
    legal    = 1'b0;
    enc_two  = 1'b0;
    enc_tail = '0;
    li_hi    = '0;
    case (req_kind)
      K_LUI: begin
        legal    = ~(|req_imm[11:0]);
        raw_word = {req_imm[31:12], req_rd, OP_LUI};
      end
      K_AUIPC: begin
        legal    = ~(|req_imm[11:0]);
        raw_word = {req_imm[31:12], req_rd, OP_AUIPC};
      end
      K_JAL: begin
        legal    = imm_j_ok;
        raw_word = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12], req_rd, OP_JAL};
      end
      K_JALR: begin
        legal    = imm_i_ok;
        raw_word = {req_imm[11:0], req_rs1, 3'b000, req_rd, OP_JALR};
      end
      K_BR: begin
        legal    = imm_b_ok && (req_funct3 != 3'b010) && (req_funct3 != 3'b011);
        raw_word = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_funct3,
                    req_imm[4:1], req_imm[11], OP_BRANCH};
      end
      K_LOAD: begin
        legal    = imm_i_ok && (req_funct3 != 3'b011) && (req_funct3 != 3'b110)
                   && (req_funct3 != 3'b111);
        raw_word = {req_imm[11:0], req_rs1, req_funct3, req_rd, OP_LOAD};
      end
      K_STORE: begin
        legal    = imm_i_ok && (req_funct3[2] == 1'b0) && (req_funct3 != 3'b011);
        raw_word = {req_imm[11:5], req_rs2, req_rs1, req_funct3, req_imm[4:0], OP_STORE};
      end
      K_IMM: begin
        if (req_funct3[1:0] == 2'b01) begin
          legal    = imm_sh_ok && !((req_funct3 == 3'b001) && req_variant);
          raw_word = {funct7, req_imm[4:0], req_rs1, req_funct3, req_rd, OP_IMM};
        end else begin
          legal    = imm_i_ok;
          raw_word = {req_imm[11:0], req_rs1, req_funct3, req_rd, OP_IMM};
        end
      end
      K_REG: begin
        legal    = !req_variant || (req_funct3 == 3'b000) || (req_funct3 == 3'b101);
        raw_word = {funct7, req_rs2, req_rs1, req_funct3, req_rd, OP_REG};
      end
      K_LI: begin
        legal = 1'b1;
        if (imm_i_ok) begin
          raw_word = {req_imm[11:0], 5'd0, 3'b000, req_rd, OP_IMM};
        end else begin
          // Round the upper part so the sign-extended low 12 bits land exactly.
          li_hi    = req_imm + 32'h0000_0800;
          raw_word = {li_hi[31:12], req_rd, OP_LUI};
          enc_two  = |req_imm[11:0];
          enc_tail = {req_imm[11:0], req_rd, 3'b000, req_rd, OP_IMM};
        end
      end
      default: legal = 1'b0;
    endcase
    enc_word = legal ? raw_word : NOP_WORD;
    enc_err  = ~legal;
    if (!legal) begin
      enc_two = 1'b0;
    end
  end

  assign fire_out  = valid_q & instr_ready;
  assign req_ready = (state_q == ST_IDLE) && (!valid_q || instr_ready);

  // Next-state and output-register logic.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    word_d  = word_q;
    err_d   = err_q;
    last_d  = last_q;
    tail_d  = tail_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          valid_d = 1'b1;
          word_d  = enc_word;
          err_d   = enc_err;
          last_d  = ~enc_two;
          if (enc_two) begin
            state_d = ST_LI_LO;
            tail_d  = enc_tail;
          end
        end else if (fire_out) begin
          valid_d = 1'b0;
        end
      end
      ST_LI_LO: begin
        if (fire_out) begin
          if (!last_q) begin
            word_d = tail_q;
            err_d  = 1'b0;
            last_d = 1'b1;
          end else begin
            valid_d = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      word_q  <= '0;
      err_q   <= 1'b0;
      last_q  <= 1'b0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      word_q  <= word_d;
      err_q   <= err_d;
      last_q  <= last_d;
      tail_q  <= tail_d;
    end
  end

  assign instr_valid = valid_q;
  assign instr_word  = word_q;
  assign instr_err   = err_q;
  assign instr_last  = last_q;

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// Bench for rv32i_instr_encoder: directed spot checks, then randomized traffic
// against an arithmetic reference model with a word scoreboard.
module tb_rv32i_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_kind;
  logic [2:0]  req_funct3;
  logic        req_variant;
  logic [4:0]  req_rd, req_rs1, req_rs2;
  logic [31:0] req_imm;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_word;
  logic        instr_err;
  logic        instr_last;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] w;
    logic        err;
    logic        last;
    logic        multi;
  } exp_t;

  exp_t exp_q[$];

  localparam logic [31:0] NOP = 32'h00000013;

  rv32i_instr_encoder dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_kind(req_kind), .req_funct3(req_funct3), .req_variant(req_variant),
    .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_word(instr_word), .instr_err(instr_err), .instr_last(instr_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] k, input logic [2:0] f3, input logic v,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] imm);
    req_kind = k; req_funct3 = f3; req_variant = v;
    req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
    req_valid = 1'b1;
  endtask

  task automatic chk_word(input string tag, input logic [31:0] w, input logic e, input logic l);
    chk({tag, "_valid"}, 32'(instr_valid), 32'd1);
    chk({tag, "_word"}, instr_word, w);
    chk({tag, "_err"}, 32'(instr_err), 32'(e));
    chk({tag, "_last"}, 32'(instr_last), 32'(l));
  endtask

  function automatic logic [31:0] bitv(input logic [31:0] x, input int n);
    return (x >> n) & 32'd1;
  endfunction

  // Reference model: expected output words of one request, from the ISA encoding rules.
  task automatic model(input logic [3:0] k, input logic [2:0] f3i, input logic v,
                       input logic [4:0] rdi, input logic [4:0] rs1i, input logic [4:0] rs2i,
                       input logic [31:0] imm);
    int          s;
    logic [31:0] rd, rs1, rs2, f3, w, hi, lo, f7;
    bit          ok;
    s = int'(imm);
    rd = 32'(rdi); rs1 = 32'(rs1i); rs2 = 32'(rs2i); f3 = 32'(f3i);
    f7 = v ? 32'h20 : 32'h0;
    ok = 1'b0;
    w = 32'd0;
    case (k)
      4'd0, 4'd1: begin
        ok = (imm & 32'hFFF) == 0;
        w = (imm & 32'hFFFFF000) | (rd << 7) | ((k == 4'd0) ? 32'h37 : 32'h17);
      end
      4'd2: begin
        ok = ((imm & 1) == 0) && s >= -(1 << 20) && s <= (1 << 20) - 2;
        w = (bitv(imm, 20) << 31) | (((imm >> 1) & 32'h3FF) << 21) | (bitv(imm, 11) << 20)
          | (((imm >> 12) & 32'hFF) << 12) | (rd << 7) | 32'h6F;
      end
      4'd3: begin
        ok = s >= -2048 && s <= 2047;
        w = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (rd << 7) | 32'h67;
      end
      4'd4: begin
        ok = f3 != 2 && f3 != 3 && ((imm & 1) == 0) && s >= -4096 && s <= 4094;
        w = (bitv(imm, 12) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20) | (rs1 << 15)
          | (f3 << 12) | (((imm >> 1) & 32'hF) << 8) | (bitv(imm, 11) << 7) | 32'h63;
      end
      4'd5: begin
        ok = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5) && s >= -2048 && s <= 2047;
        w = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h03;
      end
      4'd6: begin
        ok = f3 <= 2 && s >= -2048 && s <= 2047;
        w = (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
          | ((imm & 32'h1F) << 7) | 32'h23;
      end
      4'd7: begin
        if (f3 == 1 || f3 == 5) begin
          ok = s >= 0 && s <= 31 && !(f3 == 1 && v);
          w = (f7 << 25) | ((imm & 32'h1F) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
        end else begin
          ok = s >= -2048 && s <= 2047;
          w = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
        end
      end
      4'd8: begin
        ok = !v || f3 == 0 || f3 == 5;
        w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
      end
      4'd9: begin
        if (s >= -2048 && s <= 2047) begin
          exp_q.push_back('{((imm & 32'hFFF) << 20) | (rd << 7) | 32'h13, 1'b0, 1'b1, 1'b0});
        end else begin
          hi = (imm + 32'h800) & 32'hFFFFF000;
          lo = imm & 32'hFFF;
          if (lo == 0) begin
            exp_q.push_back('{hi | (rd << 7) | 32'h37, 1'b0, 1'b1, 1'b0});
          end else begin
            exp_q.push_back('{hi | (rd << 7) | 32'h37, 1'b0, 1'b0, 1'b1});
            exp_q.push_back('{(lo << 20) | (rd << 15) | (rd << 7) | 32'h13, 1'b0, 1'b1, 1'b1});
          end
        end
        return;
      end
      default: ok = 1'b0;
    endcase
    if (ok) exp_q.push_back('{w, 1'b0, 1'b1, 1'b0});
    else    exp_q.push_back('{NOP, 1'b1, 1'b1, 1'b0});
  endtask

  // One scoreboard cycle: check visible state against the model, then record handshakes.
  task automatic sb_cycle();
    logic exp_ready;
    exp_t e;
    chk("sb_valid", 32'(instr_valid), 32'(exp_q.size() != 0));
    exp_ready = (exp_q.size() == 0) ||
                (exp_q.size() == 1 && !exp_q[0].multi && instr_ready);
    chk("sb_req_ready", 32'(req_ready), 32'(exp_ready));
    if (instr_valid && instr_ready && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("sb_word", instr_word, e.w);
      chk("sb_err", 32'(instr_err), 32'(e.err));
      chk("sb_last", 32'(instr_last), 32'(e.last));
    end
    if (req_valid && req_ready) begin
      model(req_kind, req_funct3, req_variant, req_rd, req_rs1, req_rs2, req_imm);
    end
  endtask

  initial begin
    logic [31:0] imm;
    rst = 1'b1; req_valid = 1'b0; instr_ready = 1'b0;
    drive(4'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    req_valid = 1'b0;
    repeat (3) tick();

    // Reset state.
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_word", instr_word, 32'd0);
    chk("rst_err", 32'(instr_err), 32'd0);
    chk("rst_last", 32'(instr_last), 32'd0);
    rst = 1'b0;
    instr_ready = 1'b1;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);

    // Single-word directed requests, back to back.
    drive(4'd7, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
    tick(); chk_word("addi", 32'h00500093, 1'b0, 1'b1);
    drive(4'd8, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0);
    tick(); chk_word("sub", 32'h402081B3, 1'b0, 1'b1);
    drive(4'd7, 3'd5, 1'b1, 5'd4, 5'd1, 5'd0, 32'd3);
    tick(); chk_word("srai", 32'h4030D213, 1'b0, 1'b1);
    drive(4'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8);
    tick(); chk_word("beq", 32'h00208463, 1'b0, 1'b1);
    drive(4'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd5);
    tick(); chk_word("beq_odd", NOP, 1'b1, 1'b1);
    drive(4'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd4096);
    tick(); chk_word("beq_range", NOP, 1'b1, 1'b1);
    drive(4'd12, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    tick(); chk_word("bad_kind", NOP, 1'b1, 1'b1);

    // li with two words.
    drive(4'd9, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345678);
    tick(); req_valid = 1'b0; #1;
    chk_word("li_lui", 32'h123452B7, 1'b0, 1'b0);
    chk("li_ready_lui", 32'(req_ready), 32'd0);
    tick(); chk_word("li_addi", 32'h67828293, 1'b0, 1'b1);
    chk("li_ready_addi", 32'(req_ready), 32'd0);
    tick();
    chk("li_done_valid", 32'(instr_valid), 32'd0);
    chk("li_done_ready", 32'(req_ready), 32'd1);

    drive(4'd9, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345FFF);
    tick(); req_valid = 1'b0;
    chk_word("li2_lui", 32'h123462B7, 1'b0, 1'b0);
    tick(); chk_word("li2_addi", 32'hFFF28293, 1'b0, 1'b1);
    tick();

    drive(4'd9, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000);
    tick(); req_valid = 1'b0;
    chk_word("li3_lui", 32'h123452B7, 1'b0, 1'b1);
    tick();
    chk("li3_done", 32'(instr_valid), 32'd0);

    // Stall on the LUI word, then reset while the ADDI word is pending.
    instr_ready = 1'b0;
    drive(4'd9, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345678);
    tick(); req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk_word("stall_lui", 32'h123452B7, 1'b0, 1'b0);
      chk("stall_ready", 32'(req_ready), 32'd0);
      tick();
    end
    instr_ready = 1'b1;
    tick(); chk_word("stall_addi", 32'h67828293, 1'b0, 1'b1);
    instr_ready = 1'b0;
    rst = 1'b1;
    tick(); rst = 1'b0; #1;
    chk("mid_rst_valid", 32'(instr_valid), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    instr_ready = 1'b1;
    drive(4'd0, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h00001000);
    tick(); req_valid = 1'b0;
    chk_word("lui", 32'h000010B7, 1'b0, 1'b1);
    tick();
    chk("flush_valid", 32'(instr_valid), 32'd0);

    // Randomized traffic with random back-pressure.
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 4))
        0: imm = 32'(int'($urandom_range(0, 10000)) - 5000);
        1: imm = $urandom;
        2: imm = $urandom & 32'hFFFFF000;
        3: imm = 32'(int'($urandom_range(0, 32'h400000)) - 32'sh200000);
        default: imm = 32'($urandom_range(0, 40));
      endcase
      drive(4'($urandom_range(0, 15)), 3'($urandom), 1'($urandom), 5'($urandom),
            5'($urandom), 5'($urandom), imm);
      req_valid   = ($urandom_range(0, 3) != 0);
      instr_ready = ($urandom_range(0, 9) < 7);
      #1;
      sb_cycle();
      tick();
    end

    // Drain outstanding words within a bounded number of cycles.
    req_valid = 1'b0;
    instr_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      #1;
      sb_cycle();
      tick();
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_valid", 32'(instr_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rv32i_instr_encoder.md
Name: rv32i_instr_encoder

Overview:
- Inverse of the CPU's RV32I decode path: accepts field-level instruction requests and emits packed 32-bit RV32I instruction words.
- Used by the verification stimulus/program generator, and as an on-chip encoder for test-program injection ahead of the instruction memory model.
- Expands the `li` pseudo-op into LUI+ADDI, so one request can produce two output words.
- Registered output with a valid/ready handshake on both sides.

Parameters:
- NOP_WORD, 32'h00000013, word emitted in place of an illegal request (ADDI x0,x0,0).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  encoder can accept a request this cycle
- req_kind  in  4  0 lui, 1 auipc, 2 jal, 3 jalr, 4 br, 5 load, 6 store, 7 imm, 8 reg, 9 li; 10-15 illegal
- req_funct3  in  3  funct3 for br/load/store/imm/reg
- req_variant  in  1  selects funct7 0100000 (sub/sra/srai); otherwise 0000000
- req_rd, req_rs1, req_rs2  in  5 each  register indices
- req_imm  in  32  byte-offset / immediate value, two's complement
- instr_valid  out  1  instr_word valid
- instr_ready  in  1  consumer accepts the word
- instr_word  out  32  encoded instruction
- instr_err  out  1  request was illegal; instr_word = NOP_WORD
- instr_last  out  1  last word of the current request

Behaviour:
- Reset: instr_valid=0, instr_word=0, instr_err=0, instr_last=0, FSM=IDLE, pending LI word discarded.
- req_ready = (FSM==IDLE) && (!instr_valid || instr_ready). A request is accepted when req_valid && req_ready.
- Latency: the word is registered and valid the cycle after acceptance. Back-to-back throughput is 1 word/cycle while instr_ready=1.
- While instr_valid && !instr_ready, instr_word, instr_err and instr_last are held stable.
- FSM states:
  - IDLE -> IDLE on any single-word request.
  - IDLE -> LI_LO on an li request needing two words; the LUI word is emitted with instr_last=0.
  - LI_LO: when the LUI word handshakes, the ADDI word is loaded with instr_last=1; the FSM returns to IDLE when the ADDI word handshakes.
  - req_ready stays 0 throughout LI_LO.
- Encodings follow standard RV32I bit placement. jalr funct3 is forced to 000. Unused fields are 0.
- Immediate legality (an illegal request produces NOP_WORD, instr_err=1, instr_last=1):
  - I/S-type (jalr, load, store, imm non-shift): imm must be in [-2048, 2047].
  - Shifts (imm with funct3 001/101): imm must be in [0, 31]. imm[31:25] = funct7; funct3 001 requires req_variant=0.
  - br: imm[0]==0 and imm in [-4096, 4094].
  - jal: imm[0]==0 and imm in [-2^20, 2^20-2].
  - lui/auipc: imm[11:0]==0; the word uses imm[31:12].
- Funct3 legality:
  - load accepts only 000, 001, 010, 100, 101.
  - store accepts only 000-010.
  - br rejects 010 and 011.
  - reg with req_variant=1 is allowed only for funct3 000 and 101.
  - req_kind 10-15 is illegal.
- li (rd, imm) is always legal:
  - imm in [-2048, 2047]: single word, ADDI rd, x0, imm.
  - Otherwise: hi = (imm + 32'h800)[31:12] (32-bit wrap), emit LUI rd, hi.
  - If imm[11:0]!=0, a second word follows: ADDI rd, rd, sext(imm[11:0]).
  - If imm[11:0]==0, the LUI is the only word (instr_last=1).
- rd=x0 is legal for all kinds; no special handling.
- Reset asserted mid-li, or while a word is stalled, drops all output on the next edge.

Test Plan:
- imm kind, funct3=000, rd=1, rs1=0, imm=5 -> one cycle later instr_word=0x00500093, instr_last=1, err=0.
- reg, funct3=000, variant=1, rd=3, rs1=1, rs2=2 -> 0x402081B3. imm, funct3=101, variant=1, rd=4, rs1=1, imm=3 -> 0x4030D213.
- br beq, rs1=1, rs2=2, imm=8 -> 0x00208463. Same with imm=5 -> 0x00000013, instr_err=1. Same with imm=4096 -> err=1.
- li rd=5, imm=0x12345678 -> 0x123452B7 (last=0), then 0x67828293 (last=1); req_ready low between the two words. li rd=5, imm=0x12345FFF -> 0x123462B7, then 0xFFF28293. li rd=5, imm=0x12345000 -> single 0x123452B7, last=1.
- Hold instr_ready=0 for 5 cycles after li acceptance -> the LUI word is held stable and req_ready=0; release -> ADDI follows the next cycle.
- Assert rst while the ADDI word is pending -> next cycle instr_valid=0 and req_ready=1. A fresh lui rd=1, imm=0x1000 -> 0x000010B7.
